// File: rtl/sync_ack_pkg.sv
// Shared constants for the sync_with_ack channel arbiter.
package sync_ack_pkg;

   localparam int unsigned N_REQ_DEF       = 4;
   localparam int unsigned TIMEOUT_CYC_DEF = 64;

   // Arbiter FSM encoding
   localparam int unsigned STATE_W      = 3;
   localparam logic [2:0]  ST_IDLE      = 3'd0;
   localparam logic [2:0]  ST_SEND      = 3'd1;
   localparam logic [2:0]  ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0]  ST_WAIT_ACK  = 3'd3;
   localparam logic [2:0]  ST_DONE      = 3'd4;

endpackage

// File: rtl/sync_ack_arbiter_picker.sv
// Combinational round-robin picker: first set pend bit after last_grant, wrapping.
module rr_priority_picker #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] pend,
   input  logic [ID_W-1:0]  last_grant,
   output logic             any_c,
   output logic [ID_W-1:0]  winner_c
);

   int best_c;
   int dist_c;

   // Distance from last_grant+1 (mod N_REQ); the smallest distance among set bits wins
   always_comb begin
      best_c   = int'(N_REQ);
      dist_c   = 0;
      winner_c = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         dist_c = (i + int'(N_REQ) - int'(last_grant) - 1) % int'(N_REQ);
         if (pend[i] && (dist_c < best_c)) begin
            best_c   = dist_c;
            winner_c = ID_W'(i);
         end
      end
   end

   assign any_c = |pend;

endmodule

// File: rtl/sync_ack_arbiter.sv
// Round-robin arbiter sharing one sync_with_ack channel among N_REQ A-domain requesters.
module sync_ack_arbiter #(
   parameter int unsigned N_REQ       = sync_ack_pkg::N_REQ_DEF,
   parameter int unsigned ID_W        = $clog2(N_REQ),
   parameter int unsigned TIMEOUT_CYC = sync_ack_pkg::TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic [N_REQ-1:0] req_vld_in,
   output logic [N_REQ-1:0] req_rdy_out,
   output logic [N_REQ-1:0] req_drop_out,
   output logic             sync_vld_out,
   input  logic             sync_rdy_in,
   output logic [ID_W-1:0]  grant_id_out,
   output logic             busy_out,
   output logic             err_timeout_out
);

   import sync_ack_pkg::*;

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [STATE_W-1:0] state,      state_nxt;
   logic [N_REQ-1:0]   pend,       pend_nxt;
   logic [ID_W-1:0]    last_grant, last_nxt;
   logic [ID_W-1:0]    grant_nxt;
   logic [CNT_W-1:0]   tmo_cnt,    cnt_nxt;
   logic [CNT_W-1:0]   cnt_inc_c;
   logic               err_nxt;
   logic [N_REQ-1:0]   rdy_nxt;
   logic [N_REQ-1:0]   drop_nxt;
   logic               vld_nxt;
   logic               busy_nxt;
   logic [N_REQ-1:0]   clr_c;
   logic [N_REQ-1:0]   grant_oh_c;
   logic               pick_any_c;
   logic [ID_W-1:0]    pick_winner_c;

   rr_priority_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_picker (
      .pend       (pend),
      .last_grant (last_grant),
      .any_c      (pick_any_c),
      .winner_c   (pick_winner_c)
   );

   // One-hot decode of the current owner
   always_comb begin
      grant_oh_c = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         grant_oh_c[i] = (grant_id_out == ID_W'(i));
      end
   end

   // Saturating timeout increment
   assign cnt_inc_c = (tmo_cnt < CNT_W'(TIMEOUT_CYC)) ? (tmo_cnt + CNT_W'(1)) : tmo_cnt;

   // Next-state, pending bookkeeping and registered-output decode
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_id_out;
      last_nxt  = last_grant;
      cnt_nxt   = tmo_cnt;
      err_nxt   = err_timeout_out;
      clr_c     = '0;

      case (state)
         ST_IDLE: begin
            if (pick_any_c && sync_rdy_in) begin
               grant_nxt = pick_winner_c;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            cnt_nxt   = '0;
            state_nxt = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            cnt_nxt = cnt_inc_c;
            err_nxt = err_timeout_out | (cnt_inc_c == CNT_W'(TIMEOUT_CYC));
            if (!sync_rdy_in) begin
               state_nxt = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            cnt_nxt = cnt_inc_c;
            err_nxt = err_timeout_out | (cnt_inc_c == CNT_W'(TIMEOUT_CYC));
            if (sync_rdy_in) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            clr_c     = grant_oh_c;
            last_nxt  = grant_id_out;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // A new pulse beats the DONE clear; a pulse onto an already pending bit is dropped
      pend_nxt = (pend & ~clr_c) | req_vld_in;
      drop_nxt = req_vld_in & pend & ~clr_c;

      vld_nxt  = (state_nxt == ST_SEND);
      busy_nxt = (state_nxt != ST_IDLE);
      rdy_nxt  = (state_nxt == ST_DONE) ? grant_oh_c : '0;
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state           <= ST_IDLE;
         pend            <= '0;
         last_grant      <= ID_W'(N_REQ - 1);
         tmo_cnt         <= '0;
         grant_id_out    <= '0;
         req_rdy_out     <= '0;
         req_drop_out    <= '0;
         sync_vld_out    <= 1'b0;
         busy_out        <= 1'b0;
         err_timeout_out <= 1'b0;
      end else begin
         state           <= state_nxt;
         pend            <= pend_nxt;
         last_grant      <= last_nxt;
         tmo_cnt         <= cnt_nxt;
         grant_id_out    <= grant_nxt;
         req_rdy_out     <= rdy_nxt;
         req_drop_out    <= drop_nxt;
         sync_vld_out    <= vld_nxt;
         busy_out        <= busy_nxt;
         err_timeout_out <= err_nxt;
      end
   end

endmodule

// File: tb/tb_sync_ack_arbiter.sv
// Directed bench for sync_ack_arbiter with a simple sync_with_ack channel model.
module tb_sync_ack_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned IDW = 2;
   localparam int unsigned TMO = 8;
   localparam int          LOW = 6;

   logic           clk;
   logic           reset_in;
   logic [N-1:0]   req_vld_in;
   logic [N-1:0]   req_rdy_out;
   logic [N-1:0]   req_drop_out;
   logic           sync_vld_out;
   logic           sync_rdy_in;
   logic [IDW-1:0] grant_id_out;
   logic           busy_out;
   logic           err_timeout_out;

   int n_checks;
   int n_errors;
   int cyc;
   int t0;
   int ch_left;
   bit ch_stuck;
   int r0, r1, r2;

   int vld_id[$];
   int rdy_val[$];
   int drop_val[$];

   sync_ack_arbiter #(
      .N_REQ       (N),
      .ID_W        (IDW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk             (clk),
      .reset_in        (reset_in),
      .req_vld_in      (req_vld_in),
      .req_rdy_out     (req_rdy_out),
      .req_drop_out    (req_drop_out),
      .sync_vld_out    (sync_vld_out),
      .sync_rdy_in     (sync_rdy_in),
      .grant_id_out    (grant_id_out),
      .busy_out        (busy_out),
      .err_timeout_out (err_timeout_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge, run the channel model and log output pulses
   task automatic step();
      @(negedge clk);
      cyc++;
      if (ch_stuck) begin
         sync_rdy_in = 1'b1;
      end else if (sync_vld_out) begin
         sync_rdy_in = 1'b0;
         ch_left     = LOW;
      end else if (ch_left > 0) begin
         ch_left--;
         if (ch_left == 0) sync_rdy_in = 1'b1;
      end
      if (sync_vld_out)        vld_id.push_back(int'(grant_id_out));
      if (req_rdy_out != '0)   rdy_val.push_back(int'(req_rdy_out));
      if (req_drop_out != '0)  drop_val.push_back(int'(req_drop_out));
   endtask

   task automatic clear_logs();
      vld_id.delete();
      rdy_val.delete();
      drop_val.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rdy"},  32'(req_rdy_out),     32'd0);
      check({tag, "_drop"}, 32'(req_drop_out),    32'd0);
      check({tag, "_vld"},  32'(sync_vld_out),    32'd0);
      check({tag, "_gnt"},  32'(grant_id_out),    32'd0);
      check({tag, "_busy"}, 32'(busy_out),        32'd0);
      check({tag, "_err"},  32'(err_timeout_out), 32'd0);
   endtask

   task automatic apply_reset();
      reset_in    = 1'b0;
      req_vld_in  = '0;
      sync_rdy_in = 1'b1;
      ch_left     = 0;
      ch_stuck    = 1'b0;
      step();
      step();
      reset_in = 1'b1;
      clear_logs();
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      cyc         = 0;
      ch_left     = 0;
      ch_stuck    = 1'b0;
      reset_in    = 1'b0;
      req_vld_in  = '0;
      sync_rdy_in = 1'b1;

      // Reset values
      step();
      step();
      check_zero("reset");
      reset_in = 1'b1;
      clear_logs();
      step();

      // Single request: vld at +2, rdy pulse at +9 (channel low 6 cycles)
      req_vld_in = 4'b0001;
      t0 = cyc;
      for (int n = 1; n <= 12; n++) begin
         step();
         req_vld_in = '0;
         if (n == 1) check("single_busy_pre", 32'(busy_out), 32'd0);
         if (n == 2) begin
            check("single_vld_at2",  32'(sync_vld_out), 32'd1);
            check("single_gnt",      32'(grant_id_out), 32'd0);
            check("single_busy_on",  32'(busy_out),     32'd1);
         end
         if (n == 8) check("single_rdy_early", 32'(req_rdy_out), 32'd0);
         if (n == 9) begin
            check("single_rdy_at9",  32'(req_rdy_out),  32'b0001);
            check("single_busy_dn",  32'(busy_out),     32'd1);
         end
         if (n == 10) check("single_busy_off", 32'(busy_out), 32'd0);
      end
      check("single_nvld", 32'(vld_id.size()),  32'd1);
      check("single_nrdy", 32'(rdy_val.size()), 32'd1);
      check("single_err",  32'(err_timeout_out), 32'd0);

      // Simultaneous requests: grants 0,1,2,3
      apply_reset();
      req_vld_in = 4'b1111;
      step();
      req_vld_in = '0;
      repeat (45) step();
      check("simul_nvld",  32'(vld_id.size()),   32'd4);
      check("simul_nrdy",  32'(rdy_val.size()),  32'd4);
      check("simul_ndrop", 32'(drop_val.size()), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("simul_gnt%0d", i), 32'((i < vld_id.size()) ? vld_id[i] : -1), 32'(i));
         check($sformatf("simul_rdy%0d", i), 32'((i < rdy_val.size()) ? rdy_val[i] : -1), 32'(1 << i));
      end

      // Fairness: 0 and 2 each re-request in their DONE cycle -> 0,2,0,2
      apply_reset();
      r0 = 1;
      r2 = 1;
      req_vld_in = 4'b0101;
      for (int n = 0; n < 55; n++) begin
         step();
         req_vld_in = '0;
         if (req_rdy_out[0] && r0 > 0) begin req_vld_in[0] = 1'b1; r0--; end
         if (req_rdy_out[2] && r2 > 0) begin req_vld_in[2] = 1'b1; r2--; end
      end
      req_vld_in = '0;
      check("fair_nvld",  32'(vld_id.size()),   32'd4);
      check("fair_ndrop", 32'(drop_val.size()), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fair_gnt%0d", i), 32'((i < vld_id.size()) ? vld_id[i] : -1),
               32'(((i % 2) == 0) ? 0 : 2));
      end

      // Overflow: second pulse while pending drops; pulse in DONE cycle is kept
      apply_reset();
      req_vld_in = 4'b0010;
      t0 = cyc;
      step();
      req_vld_in = '0;
      step();
      step();
      req_vld_in = 4'b0010;
      step();
      req_vld_in = '0;
      check("ovf_drop_at4", 32'(req_drop_out), 32'b0010);
      check("ovf_busy",     32'(busy_out),     32'd1);
      r1 = 1;
      for (int n = 0; n < 30; n++) begin
         step();
         req_vld_in = '0;
         if (req_rdy_out[1] && r1 > 0) begin req_vld_in[1] = 1'b1; r1--; end
      end
      req_vld_in = '0;
      check("ovf_nvld",  32'(vld_id.size()),   32'd2);
      check("ovf_nrdy",  32'(rdy_val.size()),  32'd2);
      check("ovf_ndrop", 32'(drop_val.size()), 32'd1);
      check("ovf_rdy1",  32'((rdy_val.size() > 1) ? rdy_val[1] : -1), 32'b0010);

      // Timeout: channel never goes busy; err after 8 WAIT_BUSY cycles, FSM keeps waiting
      apply_reset();
      ch_stuck   = 1'b1;
      req_vld_in = 4'b1000;
      step();
      req_vld_in = '0;
      repeat (9) step();
      check("tmo_err_before", 32'(err_timeout_out), 32'd0);
      step();
      check("tmo_err_set",    32'(err_timeout_out), 32'd1);
      repeat (20) step();
      check("tmo_err_sticky", 32'(err_timeout_out), 32'd1);
      check("tmo_busy",       32'(busy_out),        32'd1);
      check("tmo_nvld",       32'(vld_id.size()),   32'd1);
      check("tmo_gnt",        32'(grant_id_out),    32'd3);
      check("tmo_nrdy",       32'(rdy_val.size()),  32'd0);
      reset_in = 1'b0;
      #1;
      check_zero("tmo_rst");
      ch_stuck    = 1'b0;
      sync_rdy_in = 1'b1;
      step();
      step();
      reset_in = 1'b1;
      clear_logs();

      // Reset during WAIT_ACK: immediate zero outputs, request lost
      req_vld_in = 4'b0100;
      step();
      req_vld_in = '0;
      repeat (4) step();
      check("mid_busy", 32'(busy_out), 32'd1);
      reset_in    = 1'b0;
      sync_rdy_in = 1'b1;
      ch_left     = 0;
      #1;
      check_zero("mid_rst");
      step();
      step();
      reset_in = 1'b1;
      clear_logs();
      repeat (20) step();
      check("mid_nvld", 32'(vld_id.size()),  32'd0);
      check("mid_nrdy", 32'(rdy_val.size()), 32'd0);
      check("mid_idle", 32'(busy_out),       32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
